// File: rtl/period_meter_if.sv
// Bundles the measured input and the measurement results of period_meter.
// The meter itself takes the slave view; whatever drives iSig and consumes
// the results takes the master view.
interface period_meter_if;
  logic        iSig;
  logic [13:0] oPeriod;
  logic [15:0] oBcd;
  logic        oValid;
  logic        oLocked;
  logic        oOverflow;
  logic        oMiss;

  modport slave (
    input  iSig,
    output oPeriod, oBcd, oValid, oLocked, oOverflow, oMiss
  );

  modport master (
    output iSig,
    input  oPeriod, oBcd, oValid, oLocked, oOverflow, oMiss
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: measures the period of a slow clock-like input in iClk cycles.
// A rising edge of the synchronized input restarts a saturating counter; the
// count at the next edge is the period. Each captured period is converted to
// 4 BCD digits by a 14-step serial double-dabble before the outputs update.
module period_meter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          iClk,
  input  logic          iRst,
  period_meter_if.slave bus
);

  localparam logic [13:0] MAX_COUNT = 14'd9999;
  localparam logic [3:0]  CONV_LAST = 4'd13;

  typedef enum logic [1:0] {IDLE, MEASURE, CONVERT, DONE} stateT;

  stateT stateReg, stateNext;

  logic [SYNC_STAGES-1:0] syncReg;
  logic                   histReg;
  logic                   strobe;

  logic [13:0] countReg;
  logic [13:0] capValue;
  logic        capture;
  logic        busy;

  logic [13:0] capBinReg;
  logic        capOvfReg;
  logic [13:0] binWorkReg;
  logic [15:0] bcdWorkReg;
  logic [11:0] bcdAdj;
  logic [3:0]  convCntReg;

  logic [13:0] periodReg;
  logic [15:0] bcdReg;
  logic        validReg;
  logic        lockedReg;
  logic        overflowReg;
  logic        missReg;

  // Synchronizer chain plus history flop for rising-edge detection.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      syncReg <= '0;
      histReg <= 1'b0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], bus.iSig};
      histReg <= syncReg[SYNC_STAGES-1];
    end
  end

  assign strobe = syncReg[SYNC_STAGES-1] & ~histReg;

  // Value captured at a strobe: count+1, or a pinned 9999 once saturated.
  assign capValue = (countReg == MAX_COUNT) ? MAX_COUNT : countReg + 14'd1;

  // Period counter: restarts on every strobe, saturates at 9999.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      countReg <= '0;
    end else if (strobe) begin
      countReg <= '0;
    end else if (countReg != MAX_COUNT) begin
      countReg <= countReg + 14'd1;
    end
  end

  // State register.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic; the first edge after reset only arms the meter.
  always_comb begin
    stateNext = stateReg;
    capture   = 1'b0;
    busy      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (strobe) stateNext = MEASURE;
      end
      MEASURE: begin
        if (strobe) begin
          capture   = 1'b1;
          stateNext = CONVERT;
        end
      end
      CONVERT: begin
        busy = 1'b1;
        if (convCntReg == CONV_LAST) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        stateNext = MEASURE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Add-3 correction for the three low BCD digits. The thousands digit holds
  // at most 4 before the final shift (value <= 9999), so it never needs one.
  for (genvar gi = 0; gi < 3; gi++) begin : gAdj
    assign bcdAdj[gi*4 +: 4] = (bcdWorkReg[gi*4 +: 4] >= 4'd5) ?
                               bcdWorkReg[gi*4 +: 4] + 4'd3 :
                               bcdWorkReg[gi*4 +: 4];
  end

  // Capture register and serial double-dabble converter, one shift per cycle.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      capBinReg  <= '0;
      capOvfReg  <= 1'b0;
      binWorkReg <= '0;
      bcdWorkReg <= '0;
      convCntReg <= '0;
    end else if (capture) begin
      capBinReg  <= capValue;
      capOvfReg  <= (countReg == MAX_COUNT);
      binWorkReg <= capValue;
      bcdWorkReg <= '0;
      convCntReg <= '0;
    end else if (stateReg == CONVERT) begin
      bcdWorkReg <= {bcdWorkReg[14:12], bcdAdj, binWorkReg[13]};
      binWorkReg <= {binWorkReg[12:0], 1'b0};
      convCntReg <= convCntReg + 4'd1;
    end
  end

  // Result registers, status flags and the one-cycle valid/miss pulses.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      periodReg   <= '0;
      bcdReg      <= '0;
      validReg    <= 1'b0;
      lockedReg   <= 1'b0;
      overflowReg <= 1'b0;
      missReg     <= 1'b0;
    end else begin
      validReg <= 1'b0;
      missReg  <= strobe & busy;
      if (stateReg == DONE) begin
        periodReg   <= capBinReg;
        bcdReg      <= bcdWorkReg;
        validReg    <= 1'b1;
        lockedReg   <= 1'b1;
        overflowReg <= capOvfReg;
      end else if (stateReg == MEASURE && countReg == MAX_COUNT) begin
        overflowReg <= 1'b1;
      end
    end
  end

  assign bus.oPeriod   = periodReg;
  assign bus.oBcd      = bcdReg;
  assign bus.oValid    = validReg;
  assign bus.oLocked   = lockedReg;
  assign bus.oOverflow = overflowReg;
  assign bus.oMiss     = missReg;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: drives rising edges at chosen spacings and predicts
// every oValid/oMiss event (cycle and content) from edge times alone.
module tb_period_meter;

  localparam int SYNC_STAGES = 2;
  // Input raised just after edge n is sampled at n+1; the strobe cycle ends
  // at edge n+SYNC_STAGES+1 (capture edge); outputs follow 15 edges later.
  localparam int LAT_CAP = SYNC_STAGES + 1;
  localparam int LAT_OUT = LAT_CAP + 15;

  logic iClk = 1'b0;
  logic iRst = 1'b0;
  int   cyc  = 0;

  int errors = 0;
  int checks = 0;

  period_meter_if pmBus();

  period_meter #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (pmBus)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Reference model: edge-spacing rules only.
  bit armed  = 1'b0;
  bit hasCap = 1'b0;
  int lastStrobe = 0;
  int lastCap    = 0;
  int valCyc[$];
  int valPer[$];
  int valOvf[$];
  int missCyc[$];

  task automatic modelRaise(input int n);
    int d;
    if (!armed) begin
      armed      = 1'b1;
      lastStrobe = n;
    end else begin
      d          = n - lastStrobe;
      lastStrobe = n;
      if (hasCap && (n - lastCap) >= 1 && (n - lastCap) <= 15) begin
        missCyc.push_back(n + LAT_CAP);
      end else begin
        valCyc.push_back(n + LAT_OUT);
        valPer.push_back((d >= 10000) ? 9999 : d);
        valOvf.push_back((d >= 10000) ? 1 : 0);
        hasCap  = 1'b1;
        lastCap = n;
      end
    end
  endtask

  task automatic modelReset();
    armed  = 1'b0;
    hasCap = 1'b0;
    valCyc.delete();
    valPer.delete();
    valOvf.delete();
    missCyc.delete();
  endtask

  // Monitor: every observed pulse must match the next predicted event.
  initial begin
    forever begin
      @(negedge iClk);
      if (pmBus.oValid) begin
        $display("valid @%0d period=%0d bcd=%04h ovf=%0b locked=%0b",
                 cyc, pmBus.oPeriod, pmBus.oBcd, pmBus.oOverflow, pmBus.oLocked);
        if (valCyc.size() == 0) begin
          checkVal("spuriousValid", 1, 0);
        end else begin
          int eCyc, ePer, eOvf;
          eCyc = valCyc.pop_front();
          ePer = valPer.pop_front();
          eOvf = valOvf.pop_front();
          checkVal("validCycle", cyc, eCyc);
          checkVal("period", pmBus.oPeriod, ePer);
          checkVal("bcd", pmBus.oBcd, toBcd(ePer));
          checkVal("overflow", pmBus.oOverflow, eOvf);
          checkVal("locked", pmBus.oLocked, 1);
        end
      end
      if (pmBus.oMiss) begin
        $display("miss  @%0d", cyc);
        if (missCyc.size() == 0) begin
          checkVal("spuriousMiss", 1, 0);
        end else begin
          checkVal("missCycle", cyc, missCyc.pop_front());
        end
      end
    end
  end

  int lastRaise = 0;

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge iClk);
  endtask

  // Raise iSig d cycles after the previous raise, hold it high for hi cycles.
  task automatic sigEdge(input int d, input int hi);
    int holdEnd;
    waitCyc(lastRaise + d);
    pmBus.iSig = 1'b1;
    modelRaise(cyc);
    lastRaise = cyc;
    holdEnd = cyc + hi;
    waitCyc(holdEnd);
    pmBus.iSig = 1'b0;
  endtask

  task automatic drain(input string tag);
    waitCyc(lastRaise + LAT_OUT + 2);
    checkVal(tag, valCyc.size() + missCyc.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "Period"}, pmBus.oPeriod, 0);
    checkVal({tag, "Bcd"}, pmBus.oBcd, 0);
    checkVal({tag, "Valid"}, pmBus.oValid, 0);
    checkVal({tag, "Locked"}, pmBus.oLocked, 0);
    checkVal({tag, "Overflow"}, pmBus.oOverflow, 0);
    checkVal({tag, "Miss"}, pmBus.oMiss, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pmBus.iSig = 1'b0;
    iRst = 1'b0;
    repeat (3) @(negedge iClk);
    checkAllZero("reset");
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    lastRaise = cyc;

    // Divide-by-50: first edge arms, then a 50 every period.
    sigEdge(20, 25);
    for (int i = 0; i < 6; i++) sigEdge(50, 25);
    drain("div50Pending");

    // Long period.
    for (int i = 0; i < 3; i++) sigEdge(1234, 3);
    drain("longPending");

    // Overflow: live flag while no edge arrives, then overflow capture, recovery.
    sigEdge(100, 3);
    drain("preOvfPending");
    waitCyc(lastRaise + 10001);
    checkVal("ovfNotYet", pmBus.oOverflow, 0);
    waitCyc(lastRaise + 10005);
    checkVal("ovfLive", pmBus.oOverflow, 1);
    sigEdge(12000, 3);
    drain("ovfCapPending");
    checkVal("ovfHeld", pmBus.oOverflow, 1);
    sigEdge(100, 3);
    drain("recoverPending");
    checkVal("ovfCleared", pmBus.oOverflow, 0);

    // Boundaries: largest in-range period and minimum capturable spacing.
    sigEdge(9999, 3);
    sigEdge(16, 3);
    sigEdge(16, 3);
    drain("boundaryPending");

    // Short period: captures alternate with misses.
    sigEdge(40, 2);
    for (int i = 0; i < 6; i++) sigEdge(10, 2);
    drain("shortPending");

    // Random spacings, dense then sparse.
    for (int i = 0; i < 14; i++) sigEdge(int'($urandom_range(4, 60)), 2);
    for (int i = 0; i < 6; i++) sigEdge(int'($urandom_range(16, 1500)), 2);
    drain("randomPending");

    // Reset in the middle of a conversion.
    sigEdge(200, 2);
    waitCyc(lastRaise + 10);
    iRst = 1'b0;
    modelReset();
    #1;
    checkAllZero("midReset");
    waitCyc(cyc + 3);
    iRst = 1'b1;
    lastRaise = cyc;
    sigEdge(30, 3);
    waitCyc(lastRaise + LAT_OUT + 2);
    checkVal("lockedAfterArm", pmBus.oLocked, 0);
    sigEdge(77, 3);
    drain("postResetPending");
    checkVal("lockedAfterCapture", pmBus.oLocked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
